// File: rtl/bts_pkg.sv
// bts_pkg: shared types and constants for block_transfer_sequencer
package bts_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {MODE_DA = 2'b00, MODE_IA = 2'b01, MODE_DB = 2'b10, MODE_IB = 2'b11} mode_e;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_XFER = 2'b01, ST_FIN = 2'b10} state_e;
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/lowest_bit_encoder.sv
// lowest_bit_encoder: index of the lowest set bit of a 16-bit register list
module lowest_bit_encoder (
  input  logic [15:0] list,
  output logic [3:0]  idx,
  output logic        valid
);
  // scan downward so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) if (list[i]) idx = 4'(i);
    valid = |list;
  end
endmodule

// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer: LDM/STM beat sequencer; define BTS_PC_LOAD_EN to add the pc_load output
module block_transfer_sequencer
  import bts_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base,
  input  logic [1:0]        mode,
  input  logic              writeback,
  input  logic [3:0]        base_reg,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        reg_addr,
  output logic              reg_we,
  output logic              wb_we,
  output logic [3:0]        wb_addr,
  output logic [ADDR_W-1:0] wb_data,
  output logic              busy,
  output logic              done
`ifdef BTS_PC_LOAD_EN
  ,
  output logic              pc_load
`endif
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);
  state_e            state_q, state_d;
  logic [15:0]       rem_q;
  logic [ADDR_W-1:0] addr_q, wb_val_q;
  logic              is_load_q, wb_en_q;
  logic [3:0]        base_reg_q;
  logic [3:0]        enc_idx;
  logic              enc_valid;
  logic [4:0]        n;
  logic [ADDR_W-1:0] span, start_addr, wb_val;
  mode_e             m;
  logic              last_beat;

  lowest_bit_encoder u_enc (.list(rem_q), .idx(enc_idx), .valid(enc_valid));

  assign m          = mode_e'(mode);
  assign n          = popcount16(reg_list);
  assign span       = ADDR_W'({n, 2'b00});
  assign start_addr = m == MODE_IA ? base :
                      m == MODE_IB ? base + STEP :
                      m == MODE_DA ? base - span + STEP : base - span;
  assign wb_val     = (m == MODE_IA || m == MODE_IB) ? base + span : base - span;
  assign last_beat  = (rem_q & (rem_q - 16'd1)) == '0;

  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= ST_IDLE;
    else state_q <= state_d;

  // operation context captured at start, then walked one beat per ack
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem_q      <= '0;
      addr_q     <= '0;
      wb_val_q   <= '0;
      is_load_q  <= 1'b0;
      wb_en_q    <= 1'b0;
      base_reg_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      rem_q      <= reg_list;
      addr_q     <= start_addr;
      wb_val_q   <= wb_val;
      is_load_q  <= is_load;
      wb_en_q    <= writeback & ~(is_load & reg_list[base_reg]) & (|reg_list);
      base_reg_q <= base_reg;
    end else if (state_q == ST_XFER && mem_ack) begin
      rem_q  <= rem_q & (rem_q - 16'd1);
      addr_q <= addr_q + STEP;
    end

  // next state and outputs; everything idles at zero outside its state
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    reg_addr = '0;
    reg_we   = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    done     = 1'b0;
    busy     = state_q != ST_IDLE;
    case (state_q)
      ST_IDLE: if (start) state_d = (|reg_list) ? ST_XFER : ST_FIN;
      ST_XFER: begin
        mem_req  = enc_valid;
        mem_we   = ~is_load_q;
        mem_addr = addr_q;
        reg_addr = enc_idx;
        reg_we   = is_load_q & mem_ack;
        state_d  = (mem_ack && last_beat) ? ST_FIN : ST_XFER;
      end
      ST_FIN: begin
        done    = 1'b1;
        wb_we   = wb_en_q;
        wb_addr = base_reg_q;
        wb_data = wb_val_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BTS_PC_LOAD_EN
  assign pc_load = reg_we & (reg_addr == 4'd15);
`endif
endmodule

// File: tb/tb_block_transfer_sequencer.sv
// tb_block_transfer_sequencer: randomized self-checking bench with a list-walk reference model
module tb_block_transfer_sequencer;
  logic clk = 0, reset = 1, start = 0, is_load = 0, writeback = 0, mem_ack = 0;
  logic [15:0] reg_list = '0;
  logic [31:0] base = '0;
  logic [1:0]  mode = '0;
  logic [3:0]  base_reg = '0;
  logic        mem_req, mem_we, reg_we, wb_we, busy, done;
  logic [31:0] mem_addr, wb_data;
  logic [3:0]  reg_addr, wb_addr;
`ifdef BTS_PC_LOAD_EN
  logic        pc_load;
`endif
  int errors = 0, checks = 0;

  block_transfer_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .reg_list(reg_list),
    .base(base), .mode(mode), .writeback(writeback), .base_reg(base_reg), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .reg_addr(reg_addr),
    .reg_we(reg_we), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done)
`ifdef BTS_PC_LOAD_EN
    , .pc_load(pc_load)
`endif
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic ld, input logic [15:0] lst, input logic [31:0] b,
                        input logic [1:0] md, input logic wb, input logic [3:0] br,
                        input int ack_pct, input int stall_beat);
    int n, beat, stalls, cyc;
    logic [31:0] s, wv;
    logic [3:0] regs[$];
    logic ack, exp_wb;
    n = $countones(lst);
    s = md == 2'b01 ? b : md == 2'b11 ? b + 32'd4 : md == 2'b00 ? b - 32'(4 * n) + 32'd4 : b - 32'(4 * n);
    wv = (md == 2'b01 || md == 2'b11) ? b + 32'(4 * n) : b - 32'(4 * n);
    for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(4'(i));
    exp_wb = wb && !(ld && lst[br]) && n != 0;
    @(negedge clk);
    start = 1; is_load = ld; reg_list = lst; base = b; mode = md; writeback = wb; base_reg = br; mem_ack = 0;
    @(negedge clk);
    beat = 0; stalls = 0; cyc = 0;
    while (beat < n && cyc < 400) begin
      start = 1'($urandom); is_load = 1'($urandom); reg_list = 16'($urandom);
      base = $urandom; mode = 2'($urandom); writeback = 1'($urandom); base_reg = 4'($urandom);
      if (beat == stall_beat && stalls < 3) begin ack = 0; stalls++; end
      else ack = $urandom_range(0, 99) < ack_pct;
      mem_ack = ack;
      #1;
      checks++;
      if ({mem_req, mem_we, reg_we, busy, done} !== {1'b1, ~ld, ld & ack, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL beat%0d strobes req/we/reg_we/busy/done got %b want %b", beat,
                 {mem_req, mem_we, reg_we, busy, done}, {1'b1, ~ld, ld & ack, 1'b1, 1'b0});
      end
      checks++;
      if (mem_addr !== s + 32'(4 * beat)) begin
        errors++;
        $display("FAIL beat%0d mem_addr got %h want %h", beat, mem_addr, s + 32'(4 * beat));
      end
      checks++;
      if (reg_addr !== regs[beat]) begin
        errors++;
        $display("FAIL beat%0d reg_addr got %0d want %0d", beat, reg_addr, regs[beat]);
      end
`ifdef BTS_PC_LOAD_EN
      checks++;
      if (pc_load !== (ld & ack & (regs[beat] == 4'd15))) begin
        errors++;
        $display("FAIL beat%0d pc_load got %b want %b", beat, pc_load, ld & ack & (regs[beat] == 4'd15));
      end
`endif
      if (ack) beat++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 400) begin
      errors++;
      $display("FAIL timeout beats done %0d want %0d", beat, n);
    end
    mem_ack = 1'($urandom); start = 1'($urandom);
    #1;
    checks++;
    if ({done, busy, mem_req, mem_we, reg_we} !== 5'b11000) begin
      errors++;
      $display("FAIL fin strobes done/busy/req/we/reg_we got %b want 11000", {done, busy, mem_req, mem_we, reg_we});
    end
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {exp_wb, br, wv}) begin
      errors++;
      $display("FAIL fin wb we/addr/data got %b/%0d/%h want %b/%0d/%h", wb_we, wb_addr, wb_data, exp_wb, br, wv);
    end
    @(negedge clk);
    start = 0; mem_ack = 0;
    #1;
    checks++;
    if ({done, busy, wb_we, mem_req} !== 4'b0000) begin
      errors++;
      $display("FAIL idle after fin done/busy/wb_we/req got %b want 0000", {done, busy, wb_we, mem_req});
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req, mem_we, reg_we, wb_we, done, busy, mem_addr, reg_addr, wb_addr, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset outputs got req=%b we=%b busy=%b addr=%h want all zero", mem_req, mem_we, busy, mem_addr);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_directed();
    run_op(1'b0, 16'h000E, 32'h100, 2'b01, 1'b1, 4'd13, 100, -1);
    run_op(1'b1, 16'h8001, 32'h200, 2'b10, 1'b1, 4'd2, 100, -1);
    run_op(1'b1, 16'h0030, 32'h400, 2'b01, 1'b1, 4'd4, 100, -1);
    run_op(1'b0, 16'h0003, 32'hFFFFFFFC, 2'b01, 1'b0, 4'd0, 100, -1);
    run_op(1'b1, 16'h00F0, 32'h1000, 2'b00, 1'b1, 4'd1, 100, -1);
    run_op(1'b0, 16'h0A50, 32'h2000, 2'b11, 1'b1, 4'd1, 100, -1);
  endtask

  task automatic test_stall();
    run_op(1'b1, 16'h0007, 32'h300, 2'b01, 1'b0, 4'd0, 100, 1);
  endtask

  task automatic test_empty();
    run_op(1'b0, 16'h0000, 32'h500, 2'b01, 1'b1, 4'd3, 100, -1);
    run_op(1'b1, 16'h0000, 32'h500, 2'b10, 1'b1, 4'd3, 100, -1);
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    start = 1; is_load = 0; reg_list = 16'h0007; base = 32'h700; mode = 2'b01; writeback = 1; base_reg = 4'd5;
    @(negedge clk);
    start = 0; mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    #1 reset = 1;
    #1;
    checks++;
    if ({mem_req, mem_we, reg_we, wb_we, done, busy, mem_addr, reg_addr, wb_addr, wb_data} !== '0) begin
      errors++;
      $display("FAIL mid-op reset outputs got req=%b we=%b busy=%b done=%b addr=%h want all zero",
               mem_req, mem_we, busy, done, mem_addr);
    end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({done, busy, wb_we, mem_req} !== 4'b0000) begin
        errors++;
        $display("FAIL post-reset cycle%0d done/busy/wb_we/req got %b want 0000", i, {done, busy, wb_we, mem_req});
      end
    end
    run_op(1'b0, 16'h0007, 32'h700, 2'b01, 1'b1, 4'd5, 100, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++)
      run_op(1'($urandom), 16'($urandom) & 16'($urandom), $urandom, 2'($urandom), 1'($urandom),
             4'($urandom), $urandom_range(30, 100), -1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++)
      run_op(1'($urandom), 16'($urandom), $urandom, 2'($urandom), 1'($urandom), 4'($urandom), 100, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_empty();
    test_reset_mid_op();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
